// File: rtl/cpu_pkg.sv
// cpu_pkg -- load/store width encodings and lane-mask helper shared by the MEM/WB stage.
// Rev 1.0
`default_nettype none

package cpu_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b11;

  // Byte lanes touched by an access; the unused 2'b10 code behaves as a word.
  function automatic logic [3:0] lane_mask(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: lane_mask = 4'b0001;
      WIDTH_HALF: lane_mask = 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// load_extend -- picks byte/half/word from the four addressed bytes and zero/sign-extends it.
// Rev 1.0
`default_nettype none

module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] bytes_i,
  input  logic [1:0]  width_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = bytes_i;
    case (width_i)
      WIDTH_BYTE: data_o = {{24{sign_i & bytes_i[7]}}, bytes_i[7:0]};
      WIDTH_HALF: data_o = {{16{sign_i & bytes_i[15]}}, bytes_i[15:0]};
      default:    data_o = bytes_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem.sv
// data_mem -- byte-addressed little-endian data memory with wrapping multi-byte access and write-back select.
// Rev 1.0
`default_nettype none

module data_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemToReg,
  input  logic        MemWrite,
  input  logic [1:0]  loadStoreWidth,
  input  logic        w_loadSign_1,
  input  logic [31:0] memAddr,
  input  logic [31:0] writeData,
  output logic [31:0] writeBackData
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] base_addr;
  logic [AW-1:0] lane_addr [4];
  logic [3:0]    wr_lanes;
  logic [31:0]   rd_bytes;
  logic [31:0]   load_data;

  assign base_addr = memAddr[AW-1:0];
  assign wr_lanes  = MemWrite ? lane_mask(loadStoreWidth) : 4'b0000;

  // Lane addresses wrap naturally because they are exactly AW bits wide.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i]       = base_addr + AW'(i);
      rd_bytes[8*i +: 8] = mem_q[lane_addr[i]];
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      mem_d[k] = mem_q[k];
    end
    for (int i = 0; i < 4; i++) begin
      if (wr_lanes[i]) begin
        mem_d[lane_addr[i]] = writeData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  load_extend u_load_extend (
    .bytes_i (rd_bytes),
    .width_i (loadStoreWidth),
    .sign_i  (w_loadSign_1),
    .data_o  (load_data)
  );

  assign writeBackData = MemToReg ? load_data : memAddr;

endmodule

`default_nettype wire

// File: tb/tb_data_mem.sv
// tb_data_mem -- directed scoreboard bench for data_mem.
// Rev 1.0
`default_nettype none

module tb_data_mem;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        mem_to_reg;
  logic        mem_write;
  logic [1:0]  width;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] wb_data;

  logic [31:0] sb [$];
  int          n_tests;
  int          n_fail;

  data_mem #(.DEPTH(DEPTH)) dut (
    .CLK            (clk),
    .RST            (rst),
    .MemToReg       (mem_to_reg),
    .MemWrite       (mem_write),
    .loadStoreWidth (width),
    .w_loadSign_1   (sign),
    .memAddr        (addr),
    .writeData      (wdata),
    .writeBackData  (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_wb(input string tag);
    logic [31:0] exp;
    #1;
    exp = sb.pop_front();
    n_tests++;
    assert (wb_data === exp) else begin
      n_fail++;
      $display("FAIL %s: writeBackData=%h expected %h", tag, wb_data, exp);
      $error("check %s miscompared", tag);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] w, input logic s,
                      input logic [31:0] exp, input string tag);
    @(negedge clk);
    mem_write  = 1'b0;
    mem_to_reg = 1'b1;
    addr       = a;
    width      = w;
    sign       = s;
    sb.push_back(exp);
    expect_wb(tag);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    @(negedge clk);
    mem_write = 1'b1;
    addr      = a;
    wdata     = d;
    width     = w;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    mem_to_reg = 1'b1;
    mem_write  = 1'b0;
    width      = 2'b00;
    sign       = 1'b0;
    addr       = 32'h0;
    wdata      = 32'h0;

    // T1: reset reads zero and blocks writes
    load(32'h13, 2'b00, 1'b0, 32'h0000_0000, "rst_load");
    store(32'h13, 32'hFFFF_FFFF, 2'b11);
    @(negedge clk);
    rst = 1'b0;
    load(32'h13, 2'b11, 1'b0, 32'h0000_0000, "rst_blocks_write");

    // T2: byte store with read-during-write
    @(negedge clk);
    mem_to_reg = 1'b1;
    mem_write  = 1'b1;
    addr       = 32'h13;
    wdata      = 32'h0000_00A1;
    width      = 2'b00;
    sign       = 1'b0;
    sb.push_back(32'h0000_0000);
    expect_wb("rdw_old");
    @(posedge clk);
    sb.push_back(32'h0000_00A1);
    expect_wb("rdw_new");
    mem_write = 1'b0;
    load(32'h13, 2'b00, 1'b1, 32'hFFFF_FFA1, "byte_signed");
    load(32'h13, 2'b00, 1'b0, 32'h0000_00A1, "byte_unsigned");
    load(32'hFFFF_FF13, 2'b00, 1'b0, 32'h0000_00A1, "upper_addr_ignored");

    // T3: unaligned half
    store(32'h11, 32'h0000_A1A1, 2'b01);
    load(32'h11, 2'b01, 1'b1, 32'hFFFF_A1A1, "half_signed");
    load(32'h11, 2'b01, 1'b0, 32'h0000_A1A1, "half_unsigned");
    load(32'h11, 2'b00, 1'b0, 32'h0000_00A1, "half_b0");
    load(32'h12, 2'b00, 1'b0, 32'h0000_00A1, "half_b1");
    load(32'h10, 2'b00, 1'b0, 32'h0000_0000, "half_below_untouched");

    // T4: unaligned word
    store(32'h12, 32'h00A1_A1A1, 2'b11);
    load(32'h12, 2'b11, 1'b0, 32'h00A1_A1A1, "word_load");
    load(32'h15, 2'b00, 1'b0, 32'h0000_0000, "word_top_byte");
    load(32'h11, 2'b00, 1'b0, 32'h0000_00A1, "word_below_kept");
    load(32'h12, 2'b10, 1'b1, 32'h00A1_A1A1, "width10_as_word");
    load(32'h13, 2'b01, 1'b1, 32'hFFFF_A1A1, "half_sign_from_b1");
    load(32'h14, 2'b01, 1'b1, 32'h0000_00A1, "half_sign_b1_clear");

    // T5: ALU bypass and no-write cycle
    @(negedge clk);
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    sign       = 1'bx;
    addr       = 32'h13;
    sb.push_back(32'h0000_0013);
    expect_wb("bypass_13");
    @(negedge clk);
    addr = 32'hABCD_0013;
    sb.push_back(32'hABCD_0013);
    expect_wb("bypass_full");
    @(negedge clk);
    addr  = 32'h12;
    width = 2'b11;
    wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    load(32'h12, 2'b11, 1'b0, 32'h00A1_A1A1, "no_write_kept");

    // T6: wrap at top of memory
    store(DEPTH - 2, 32'h1122_3344, 2'b11);
    load(DEPTH - 2, 2'b00, 1'b0, 32'h0000_0044, "wrap_b0");
    load(DEPTH - 1, 2'b00, 1'b0, 32'h0000_0033, "wrap_b1");
    load(32'h00,    2'b00, 1'b0, 32'h0000_0022, "wrap_b2");
    load(32'h01,    2'b00, 1'b0, 32'h0000_0011, "wrap_b3");
    load(DEPTH - 2, 2'b11, 1'b0, 32'h1122_3344, "wrap_word");
    load(DEPTH - 1, 2'b01, 1'b1, 32'h0000_2233, "wrap_half");
    load(DEPTH - 1, 2'b10, 1'b0, 32'h0011_2233, "wrap_width10");

    // Byte store ignores upper data bits and neighbours
    store(32'h01, 32'hFFFF_FF5A, 2'b00);
    load(32'h00, 2'b11, 1'b0, 32'h0000_5A22, "byte_neighbours");

    // Asynchronous reset clears memory without a clock edge
    @(negedge clk);
    mem_to_reg = 1'b1;
    addr       = DEPTH - 2;
    width      = 2'b11;
    sign       = 1'b0;
    rst        = 1'b1;
    sb.push_back(32'h0000_0000);
    expect_wb("async_rst");
    @(negedge clk);
    rst = 1'b0;
    load(32'h12, 2'b11, 1'b0, 32'h0000_0000, "after_rst_cleared");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
